// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: pipeline tracking entry, register address
// type and forward-select width helper.
package hazard_pkg;

   typedef logic [4:0] reg_addr_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      logic      we;
      logic      is_load;
   } track_entry_t;

   function automatic int unsigned fwd_sel_w(input int unsigned num_fwd);
      return $clog2(num_fwd + 1);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority encoder for one source operand against the tracked stages.
// Entry k sits at bit k-1 of each flattened input.
module fwd_match
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_FWD = 3,
   parameter int unsigned SEL_W   = fwd_sel_w(NUM_FWD)
) (
   input  logic [NUM_FWD-1:0]   i_valid,
   input  logic [NUM_FWD-1:0]   i_we,
   input  logic [NUM_FWD-1:0]   i_is_load,
   input  logic [5*NUM_FWD-1:0] i_rd,
   input  logic [4:0]           i_rs,
   input  logic                 i_rs_used,
   output logic [SEL_W-1:0]     o_sel,
   output logic                 o_is_load
);

   always_comb begin
      o_sel     = '0;
      o_is_load = 1'b0;
      // Walk oldest to youngest so the youngest match is written last and wins.
      for (int k = NUM_FWD; k >= 1; k--) begin
         if (i_valid[k-1] && i_we[k-1] && (i_rd[5*(k-1) +: 5] == i_rs) &&
             (i_rs != 5'd0) && i_rs_used) begin
            o_sel     = SEL_W'(k);
            o_is_load = i_is_load[k-1];
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding select, load-use stall, taken-branch
// flush and saturating stall/flush performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned  NUM_FWD    = 3,
   parameter int unsigned  LOAD_LAT   = 1,
   parameter int unsigned  BR_PENALTY = 2,
   parameter int unsigned  CNT_W      = 16,
   localparam int unsigned SEL_W      = fwd_sel_w(NUM_FWD)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_id_valid,
   input  logic [4:0]         i_id_rs1,
   input  logic [4:0]         i_id_rs2,
   input  logic               i_id_rs1_used,
   input  logic               i_id_rs2_used,
   input  logic [4:0]         i_id_rd,
   input  logic               i_id_rd_we,
   input  logic               i_id_is_load,
   input  logic               i_ex_branch_taken,
   output logic [SEL_W-1:0]   o_fwd_sel_rs1,
   output logic [SEL_W-1:0]   o_fwd_sel_rs2,
   output logic               o_stall,
   output logic               o_flush,
   output logic [NUM_FWD-1:0] o_stage_valid,
   output logic [CNT_W-1:0]   o_stall_cycles,
   output logic [CNT_W-1:0]   o_flush_cycles
);

   track_entry_t [NUM_FWD-1:0] r_track;
   logic [1:0]                 r_flush_cnt;
   logic [CNT_W-1:0]           r_stall_cycles;
   logic [CNT_W-1:0]           r_flush_cycles;

   logic [NUM_FWD-1:0]   w_valid;
   logic [NUM_FWD-1:0]   w_we;
   logic [NUM_FWD-1:0]   w_is_load;
   logic [5*NUM_FWD-1:0] w_rd;
   logic [SEL_W-1:0]     w_sel_rs1;
   logic [SEL_W-1:0]     w_sel_rs2;
   logic                 w_rs1_load;
   logic                 w_rs2_load;
   logic                 w_load_use;
   logic                 w_flush;
   logic                 w_stall;
   track_entry_t         w_id_entry;

   for (genvar k = 0; k < NUM_FWD; k++) begin : g_unpack
      assign w_valid[k]      = r_track[k].valid;
      assign w_we[k]         = r_track[k].we;
      assign w_is_load[k]    = r_track[k].is_load;
      assign w_rd[5*k +: 5]  = r_track[k].rd;
   end

   fwd_match #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_match_rs1 (
      .i_valid   (w_valid),
      .i_we      (w_we),
      .i_is_load (w_is_load),
      .i_rd      (w_rd),
      .i_rs      (i_id_rs1),
      .i_rs_used (i_id_rs1_used),
      .o_sel     (w_sel_rs1),
      .o_is_load (w_rs1_load)
   );

   fwd_match #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_match_rs2 (
      .i_valid   (w_valid),
      .i_we      (w_we),
      .i_is_load (w_is_load),
      .i_rd      (w_rd),
      .i_rs      (i_id_rs2),
      .i_rs_used (i_id_rs2_used),
      .o_sel     (w_sel_rs2),
      .o_is_load (w_rs2_load)
   );

   // A load flag from the encoder implies a nonzero select, so only the age needs testing.
   assign w_load_use = i_id_valid &&
                       ((w_rs1_load && (w_sel_rs1 <= SEL_W'(LOAD_LAT))) ||
                        (w_rs2_load && (w_sel_rs2 <= SEL_W'(LOAD_LAT))));

   // Reset gating keeps a branch pulse seen during reset from raising flush.
   assign w_flush = i_rst_n && (i_ex_branch_taken || (r_flush_cnt != 2'd0));
   assign w_stall = w_load_use && !w_flush;

   always_comb begin
      w_id_entry         = '0;
      w_id_entry.valid   = i_id_valid && !w_stall && !w_flush;
      w_id_entry.rd      = i_id_rd;
      w_id_entry.we      = i_id_rd_we;
      w_id_entry.is_load = i_id_is_load;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_track        <= '0;
         r_flush_cnt    <= 2'd0;
         r_stall_cycles <= '0;
         r_flush_cycles <= '0;
      end else begin
         r_track[0] <= w_id_entry;
         for (int k = 1; k < NUM_FWD; k++) begin
            r_track[k] <= r_track[k-1];
         end
         // Branches arriving while the counter runs are dropped.
         if (r_flush_cnt != 2'd0) begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
         end else if (i_ex_branch_taken) begin
            r_flush_cnt <= 2'(BR_PENALTY - 1);
         end
         if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         if (w_flush && (r_flush_cycles != '1)) begin
            r_flush_cycles <= r_flush_cycles + CNT_W'(1);
         end
      end
   end

   assign o_fwd_sel_rs1  = w_sel_rs1;
   assign o_fwd_sel_rs2  = w_sel_rs2;
   assign o_stall        = w_stall;
   assign o_flush        = w_flush;
   assign o_stage_valid  = w_valid;
   assign o_stall_cycles = r_stall_cycles;
   assign o_flush_cycles = r_flush_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default build and a NUM_FWD=4/LOAD_LAT=2/BR_PENALTY=3/CNT_W=4
// build share stimulus and are each checked every cycle against a queue-style model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, rs1_used, rs2_used, rd_we, is_load, br;
   logic [4:0] rs1, rs2, rd;

   logic [1:0]  a_sel1, a_sel2;
   logic        a_stall, a_flush;
   logic [2:0]  a_sv;
   logic [15:0] a_scnt, a_fcnt;
   logic [2:0]  b_sel1, b_sel2;
   logic        b_stall, b_flush;
   logic [3:0]  b_sv;
   logic [3:0]  b_scnt, b_fcnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state per build (index 0 = default, 1 = alternate); stage k at [k].
   bit         m_valid [2][5];
   logic [4:0] m_rd    [2][5];
   bit         m_we    [2][5];
   bit         m_ld    [2][5];
   int         m_rem   [2];
   int         m_scnt  [2];
   int         m_fcnt  [2];

   always #5 clk = ~clk;

   hazard_ctrl u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
      .i_id_rd(rd), .i_id_rd_we(rd_we), .i_id_is_load(is_load), .i_ex_branch_taken(br),
      .o_fwd_sel_rs1(a_sel1), .o_fwd_sel_rs2(a_sel2), .o_stall(a_stall), .o_flush(a_flush),
      .o_stage_valid(a_sv), .o_stall_cycles(a_scnt), .o_flush_cycles(a_fcnt)
   );

   hazard_ctrl #(.NUM_FWD(4), .LOAD_LAT(2), .BR_PENALTY(3), .CNT_W(4)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
      .i_id_rd(rd), .i_id_rd_we(rd_we), .i_id_is_load(is_load), .i_ex_branch_taken(br),
      .o_fwd_sel_rs1(b_sel1), .o_fwd_sel_rs2(b_sel2), .o_stall(b_stall), .o_flush(b_flush),
      .o_stage_valid(b_sv), .o_stall_cycles(b_scnt), .o_flush_cycles(b_fcnt)
   );

   function automatic int nf(input int d);
      return (d == 0) ? 3 : 4;
   endfunction
   function automatic int ll(input int d);
      return (d == 0) ? 1 : 2;
   endfunction
   function automatic int bp(input int d);
      return (d == 0) ? 2 : 3;
   endfunction
   function automatic int cmax(input int d);
      return (d == 0) ? 65535 : 15;
   endfunction

   task automatic model_reset(input int d);
      for (int k = 0; k < 5; k++) m_valid[d][k] = 1'b0;
      m_rem[d]  = 0;
      m_scnt[d] = 0;
      m_fcnt[d] = 0;
   endtask

   function automatic void model_eval(input int d, output int s1, output int s2,
                                      output bit st, output bit fl);
      bit ld1, ld2;
      s1 = 0; s2 = 0; ld1 = 1'b0; ld2 = 1'b0; st = 1'b0; fl = 1'b0;
      if (rst_n === 1'b1) begin
         for (int k = 1; k <= nf(d); k++) begin
            if (s1 == 0 && m_valid[d][k] && m_we[d][k] && m_rd[d][k] == rs1 &&
                rs1 != 5'd0 && rs1_used) begin
               s1 = k; ld1 = m_ld[d][k];
            end
            if (s2 == 0 && m_valid[d][k] && m_we[d][k] && m_rd[d][k] == rs2 &&
                rs2 != 5'd0 && rs2_used) begin
               s2 = k; ld2 = m_ld[d][k];
            end
         end
         fl = (m_rem[d] > 0) || br;
         st = id_valid && ((ld1 && s1 <= ll(d)) || (ld2 && s2 <= ll(d))) && !fl;
      end
   endfunction

   task automatic model_clock(input int d);
      int s1, s2;
      bit st, fl;
      if (rst_n !== 1'b1) begin
         model_reset(d);
      end else begin
         model_eval(d, s1, s2, st, fl);
         for (int k = nf(d); k >= 2; k--) begin
            m_valid[d][k] = m_valid[d][k-1];
            m_rd[d][k]    = m_rd[d][k-1];
            m_we[d][k]    = m_we[d][k-1];
            m_ld[d][k]    = m_ld[d][k-1];
         end
         m_valid[d][1] = id_valid && !st && !fl;
         m_rd[d][1]    = rd;
         m_we[d][1]    = rd_we;
         m_ld[d][1]    = is_load;
         if (m_rem[d] > 0) m_rem[d]--;
         else if (br) m_rem[d] = bp(d) - 1;
         if (st && m_scnt[d] < cmax(d)) m_scnt[d]++;
         if (fl && m_fcnt[d] < cmax(d)) m_fcnt[d]++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic check_dut(input int d);
      int s1, s2;
      bit st, fl;
      logic [31:0] sv;
      model_eval(d, s1, s2, st, fl);
      sv = '0;
      for (int k = 1; k <= nf(d); k++) if (m_valid[d][k]) sv[k-1] = 1'b1;
      if (d == 0) begin
         chk("a_fwd1", 32'(a_sel1), s1);
         chk("a_fwd2", 32'(a_sel2), s2);
         chk("a_stall", 32'(a_stall), 32'(st));
         chk("a_flush", 32'(a_flush), 32'(fl));
         chk("a_stage_valid", 32'(a_sv), sv);
         chk("a_stall_cycles", 32'(a_scnt), m_scnt[0]);
         chk("a_flush_cycles", 32'(a_fcnt), m_fcnt[0]);
      end else begin
         chk("b_fwd1", 32'(b_sel1), s1);
         chk("b_fwd2", 32'(b_sel2), s2);
         chk("b_stall", 32'(b_stall), 32'(st));
         chk("b_flush", 32'(b_flush), 32'(fl));
         chk("b_stage_valid", 32'(b_sv), sv);
         chk("b_stall_cycles", 32'(b_scnt), m_scnt[1]);
         chk("b_flush_cycles", 32'(b_fcnt), m_fcnt[1]);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      check_dut(0);
      check_dut(1);
   endtask

   task automatic advance();
      @(posedge clk);
      model_clock(0);
      model_clock(1);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2, input logic [4:0] dst,
                         input logic we, input logic ld);
      id_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
      rd = dst; rd_we = we; is_load = ld;
   endtask

   initial begin
      rst_n = 1'b0;
      br    = 1'b0;
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1);
      model_reset(0);
      model_reset(1);
      #1;

      // Held in reset with live ID inputs: everything quiet.
      sample();
      chk("rst_flush", 32'(a_flush), 0);
      advance();
      br = 1'b1;
      sample();
      chk("rst_flush_br", 32'(b_flush), 0);
      advance();
      br    = 1'b0;
      rst_n = 1'b1;

      // ALU producer in EX forwards from stage 1.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      sample(); advance();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      sample();
      chk("alu_fwd1", 32'(a_sel1), 1);
      chk("alu_nostall", 32'(a_stall), 0);
      advance();

      // Load-use: one stall cycle, then forward from stage 2.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      sample(); advance();
      set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      sample();
      chk("lu_stall", 32'(a_stall), 1);
      advance();
      sample();
      chk("lu_release", 32'(a_stall), 0);
      chk("lu_fwd2", 32'(a_sel2), 2);
      advance();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      sample();
      chk("lu_stall_cycles", 32'(a_scnt), 1);
      advance();

      // Younger ALU write shadows an older load; x0 never forwards.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      sample(); advance();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      sample(); advance();
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      sample(); advance();
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      sample();
      chk("shadow_fwd1", 32'(a_sel1), 1);
      chk("shadow_nostall", 32'(a_stall), 0);
      chk("x0_fwd2", 32'(a_sel2), 0);
      advance();

      // Branch coinciding with load-use; second pulse during flush is dropped.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      sample(); advance();
      set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      br = 1'b1;
      sample();
      chk("br_flush1", 32'(a_flush), 1);
      chk("br_nostall1", 32'(a_stall), 0);
      advance();
      sample();
      chk("br_flush2", 32'(a_flush), 1);
      chk("br_nostall2", 32'(a_stall), 0);
      advance();
      br = 1'b0;
      sample();
      chk("br_flush_end", 32'(a_flush), 0);
      chk("br_flush_cycles", 32'(a_fcnt), 2);
      advance();

      // Reset asserted in the first cycle of a 3-cycle flush.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
      sample(); advance();
      sample(); advance();
      br = 1'b1;
      sample();
      chk("rf_flush_on", 32'(b_flush), 1);
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      #1;
      chk("rf_flush_off", 32'(b_flush), 0);
      chk("rf_stage_valid", 32'(b_sv), 0);
      chk("rf_flush_cycles", 32'(b_fcnt), 0);
      chk("rf_stall_cycles", 32'(b_scnt), 0);
      advance();
      br    = 1'b0;
      rst_n = 1'b1;
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      sample();
      chk("rf_post_flush", 32'(b_flush), 0);
      advance();

      // Repeated load-use pairs drive the 4-bit stall counter into saturation.
      for (int n = 0; n < 12; n++) begin
         set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
         sample(); advance();
         set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
         for (int c = 0; c < 3; c++) begin
            sample(); advance();
         end
      end
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      sample();
      chk("sat_stall_cycles", 32'(b_scnt), 15);
      advance();

      // Randomized traffic over a small register window to provoke frequent matches.
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(99) != 0);
         if (!rst_n) begin
            model_reset(0);
            model_reset(1);
         end
         set_id(1'($urandom_range(3) != 0), 5'($urandom_range(3)), 1'($urandom_range(1)),
                5'($urandom_range(3)), 1'($urandom_range(1)), 5'($urandom_range(3)),
                1'($urandom_range(1)), 1'($urandom_range(2) == 0));
         br = ($urandom_range(7) == 0);
         sample(); advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
